// File: rtl/muldiv_hilo_ctrl.sv
// muldiv_hilo_ctrl: owns HI/LO and sequences MULT/MULTU/DIV/DIVU/MTHI/MTLO
// signed ops run on the unsigned cores with a sign-magnitude fix-up at WB
module muldiv_hilo_ctrl #(
  parameter int W           = 32,
  parameter bit DIV0_BYPASS = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           op_valid,
  input  logic [2:0]     md_op,
  input  logic [W-1:0]   rs_val,
  input  logic [W-1:0]   rt_val,
  output logic           op_ready,
  output logic           md_busy,
  output logic           done,
  output logic [W-1:0]   hi,
  output logic [W-1:0]   lo,
  output logic           mul_start,
  output logic [W-1:0]   mul_a,
  output logic [W-1:0]   mul_b,
  input  logic [2*W-1:0] mul_res,
  input  logic           mul_busy,
  output logic           div_start,
  output logic [W-1:0]   div_a,
  output logic [W-1:0]   div_b,
  input  logic [W-1:0]   div_q,
  input  logic [W-1:0]   div_r,
  input  logic           div_busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_ARM   = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_WB    = 3'd4;

  localparam logic [W-1:0]   ONE  = 1;
  localparam logic [2*W-1:0] ONE2 = 1;

  logic [2:0]     state_q, state_d;
  logic [W-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [W-1:0]   mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic [W-1:0]   div_a_q, div_a_d, div_b_q, div_b_d;
  logic [2*W-1:0] res_q, res_d;
  logic           neg_q, neg_d, rneg_q, rneg_d;
  logic           sel_div_q, sel_div_d;
  logic           done_q, done_d;
  logic           mst_q, mst_d, dst_q, dst_d;

  logic           accept, is_md, is_div, sgn;
  logic           a_neg, b_neg, div0, core_idle;
  logic [W-1:0]   mag_a, mag_b, q_fix, r_fix;
  logic [2*W-1:0] prod_fix;

  assign accept = op_valid && (state_q == S_IDLE);
  assign is_md  = ~md_op[2];
  assign is_div = md_op[1];
  assign sgn    = ~md_op[0];
  assign a_neg  = sgn & rs_val[W-1];
  assign b_neg  = sgn & rt_val[W-1];
  assign mag_a  = a_neg ? ~rs_val + ONE : rs_val;
  assign mag_b  = b_neg ? ~rt_val + ONE : rt_val;
  assign div0   = DIV0_BYPASS && is_div
               && (rt_val == '0);

  assign core_idle = sel_div_q ? ~div_busy
                               : ~mul_busy;

  assign prod_fix = neg_q ? ~res_q + ONE2 : res_q;
  assign q_fix = neg_q
    ? ~res_q[W-1:0] + ONE : res_q[W-1:0];
  assign r_fix = rneg_q
    ? ~res_q[2*W-1:W] + ONE : res_q[2*W-1:W];

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    mul_a_d   = mul_a_q;
    mul_b_d   = mul_b_q;
    div_a_d   = div_a_q;
    div_b_d   = div_b_q;
    res_d     = res_q;
    neg_d     = neg_q;
    rneg_d    = rneg_q;
    sel_div_d = sel_div_q;
    done_d    = 1'b0;
    mst_d     = 1'b0;
    dst_d     = 1'b0;
    case (state_q)
      S_IDLE: if (accept) begin
        unique case (1'b1)
          is_md && is_div && div0: begin
            // preload the raw result; WB writes it with no sign fix
            res_d     = {rs_val, {W{1'b1}}};
            neg_d     = 1'b0;
            rneg_d    = 1'b0;
            sel_div_d = 1'b1;
            state_d   = S_WB;
          end
          is_md && is_div && !div0: begin
            div_a_d   = mag_a;
            div_b_d   = mag_b;
            neg_d     = a_neg ^ b_neg;
            rneg_d    = a_neg;
            sel_div_d = 1'b1;
            state_d   = S_ISSUE;
          end
          is_md && !is_div: begin
            mul_a_d   = mag_a;
            mul_b_d   = mag_b;
            neg_d     = a_neg ^ b_neg;
            rneg_d    = a_neg;
            sel_div_d = 1'b0;
            state_d   = S_ISSUE;
          end
          md_op == 3'd4: hi_d = rs_val;
          md_op == 3'd5: lo_d = rs_val;
          default: ;
        endcase
      end
      S_ISSUE: begin
        mst_d   = ~sel_div_q;
        dst_d   = sel_div_q;
        state_d = S_ARM;
      end
      S_ARM: state_d = S_WAIT;
      S_WAIT: if (core_idle) begin
        res_d = sel_div_q ? {div_r, div_q}
                          : mul_res;
        state_d = S_WB;
      end
      S_WB: begin
        if (sel_div_q) begin
          lo_d = q_fix;
          hi_d = r_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      div_a_q   <= '0;
      div_b_q   <= '0;
      res_q     <= '0;
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
      sel_div_q <= 1'b0;
      done_q    <= 1'b0;
      mst_q     <= 1'b0;
      dst_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      mul_a_q   <= mul_a_d;
      mul_b_q   <= mul_b_d;
      div_a_q   <= div_a_d;
      div_b_q   <= div_b_d;
      res_q     <= res_d;
      neg_q     <= neg_d;
      rneg_q    <= rneg_d;
      sel_div_q <= sel_div_d;
      done_q    <= done_d;
      mst_q     <= mst_d;
      dst_q     <= dst_d;
    end
  end

  assign op_ready  = (state_q == S_IDLE);
  assign md_busy   = ~op_ready;
  assign done      = done_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign mul_start = mst_q;
  assign div_start = dst_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign div_a     = div_a_q;
  assign div_b     = div_b_q;

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// tb_muldiv_hilo_ctrl: random ops against an arithmetic HI/LO model
// plus fixed cases; cores modelled as busy-for-N-cycles units
module tb_muldiv_hilo_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        op_valid = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] rs_val = '0, rt_val = '0;
  logic        op_ready, md_busy, done;
  logic [31:0] hi, lo;
  logic        mul_start, div_start;
  logic [31:0] mul_a, mul_b, div_a, div_b;
  logic [63:0] mul_res;
  logic        mul_busy;
  logic [31:0] div_q, div_r;
  logic        div_busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  muldiv_hilo_ctrl #(.W(32), .DIV0_BYPASS(1'b1)) dut (
    .clk(clk), .reset(reset),
    .op_valid(op_valid), .md_op(md_op),
    .rs_val(rs_val), .rt_val(rt_val),
    .op_ready(op_ready), .md_busy(md_busy),
    .done(done), .hi(hi), .lo(lo),
    .mul_start(mul_start), .mul_a(mul_a),
    .mul_b(mul_b), .mul_res(mul_res),
    .mul_busy(mul_busy),
    .div_start(div_start), .div_a(div_a),
    .div_b(div_b), .div_q(div_q),
    .div_r(div_r), .div_busy(div_busy)
  );

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // core models: busy rises the edge after start, held N cycles
  int dlat_next = 3;
  int m_dlat = 3;
  int mcnt, dcnt;
  int n_dstart = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mul_busy <= 1'b0;
      mcnt     <= 0;
      mul_res  <= '0;
    end else if (mul_start) begin
      mul_busy <= 1'b1;
      mcnt     <= 5;
    end else if (mul_busy) begin
      if (mcnt == 0) begin
        mul_busy <= 1'b0;
        mul_res  <= {32'h0, mul_a} * {32'h0, mul_b};
      end else mcnt <= mcnt - 1;
    end
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      div_busy <= 1'b0;
      dcnt     <= 0;
      div_q    <= '0;
      div_r    <= '0;
    end else if (div_start) begin
      n_dstart++;
      div_busy <= 1'b1;
      dcnt     <= m_dlat - 1;
    end else if (div_busy) begin
      if (dcnt == 0) begin
        div_busy <= 1'b0;
        div_q <= (div_b == 0) ? 32'hFFFF_FFFF
                              : div_a / div_b;
        div_r <= (div_b == 0) ? div_a
                              : div_a % div_b;
      end else dcnt <= dcnt - 1;
    end
  end

  // behavioural model: op outcome from plain arithmetic + fixed latency
  bit          m_pend = 0, m_done = 0;
  bit          m_ismul = 0, m_isdiv = 0;
  int          m_left = 0, m_age = 0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [31:0] e_hi, e_lo, m_ma, m_mb;
  logic [63:0] m_p;
  longint      sa, sb, sq, sr;

  function automatic logic [31:0] mag(
      input bit s, input logic [31:0] x);
    return (s && x[31]) ? 32'h0 - x : x;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pend = 0; m_done = 0;
      m_hi = '0; m_lo = '0;
      m_ismul = 0; m_isdiv = 0;
    end else begin
      m_done = 0;
      if (m_pend) begin
        m_age++;
        m_left--;
        if (m_left == 0) begin
          m_hi = e_hi; m_lo = e_lo;
          m_pend = 0; m_done = 1;
          m_ismul = 0; m_isdiv = 0;
        end
      end else if (op_valid) begin
        m_age = 0;
        case (md_op)
          3'd0, 3'd1: begin
            if (md_op == 3'd0) begin
              sa = longint'($signed(rs_val));
              sb = longint'($signed(rt_val));
              m_p = 64'(sa * sb);
            end else
              m_p = {32'h0, rs_val} * {32'h0, rt_val};
            e_hi = m_p[63:32]; e_lo = m_p[31:0];
            m_ma = mag(md_op == 3'd0, rs_val);
            m_mb = mag(md_op == 3'd0, rt_val);
            m_pend = 1; m_ismul = 1; m_left = 10;
          end
          3'd2, 3'd3: begin
            m_pend = 1;
            if (rt_val == 0) begin
              e_lo = 32'hFFFF_FFFF; e_hi = rs_val;
              m_left = 1;
            end else begin
              if (md_op == 3'd2) begin
                sa = longint'($signed(rs_val));
                sb = longint'($signed(rt_val));
              end else begin
                sa = longint'({32'h0, rs_val});
                sb = longint'({32'h0, rt_val});
              end
              sq = sa / sb; sr = sa % sb;
              e_lo = sq[31:0]; e_hi = sr[31:0];
              m_ma = mag(md_op == 3'd2, rs_val);
              m_mb = mag(md_op == 3'd2, rt_val);
              m_isdiv = 1;
              m_dlat = dlat_next;
              m_left = dlat_next + 4;
            end
          end
          3'd4: m_hi = rs_val;
          3'd5: m_lo = rs_val;
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    chk("op_ready", op_ready, !m_pend);
    chk("md_busy", md_busy, m_pend);
    chk("done", done, m_done);
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    chk("mul_start", mul_start,
        m_pend && m_ismul && m_age == 1);
    chk("div_start", div_start,
        m_pend && m_isdiv && m_age == 1);
    if (m_pend && m_ismul) begin
      chk("mul_a", mul_a, m_ma);
      chk("mul_b", mul_b, m_mb);
    end
    if (m_pend && m_isdiv) begin
      chk("div_a", div_a, m_ma);
      chk("div_b", div_b, m_mb);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input int dl);
    bit acc;
    dlat_next = dl;
    op_valid = 1'b1;
    md_op = op; rs_val = a; rt_val = b;
    acc = 0;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = op_ready;
      step();
    end
    op_valid = 1'b0;
    if (!acc) chk("accept_timeout", acc, 1);
  endtask

  task automatic wait_done(output int n);
    bit got;
    n = 0; got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      got = done;
    end
    chk("done_timeout", got, 1);
  endtask

  task automatic wait_idle();
    bit rdy;
    rdy = 0;
    for (int i = 0; i < 100 && !rdy; i++) begin
      @(negedge clk);
      rdy = op_ready;
    end
    chk("idle_timeout", rdy, 1);
    step();
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20)) - 32'd10;
      default: return $urandom;
    endcase
  endfunction

  int n, ds0;
  logic [31:0] ra, rb;

  initial begin
    repeat (3) step();
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_ready", op_ready, 1);
    chk("rst_done", done, 0);
    reset = 1'b0;
    step();

    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3);
    wait_done(n);
    chk("multu_lat", n, 10);
    chk("multu_hi", hi, 32'hFFFF_FFFE);
    chk("multu_lo", lo, 32'h0000_0001);

    issue(3'd0, 32'hFFFF_FFFD, 32'd7, 3);
    @(negedge clk);
    chk("mult_a", mul_a, 3);
    chk("mult_b", mul_b, 7);
    step();
    issue(3'd4, 32'h1234, 32'd0, 3);
    @(negedge clk);
    chk("mthi_hi", hi, 32'h1234);
    chk("mult_lo", lo, 32'hFFFF_FFEB);
    step();

    issue(3'd2, 32'hFFFF_FFF9, 32'd2, 3);
    wait_done(n);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    step();

    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5);
    wait_done(n);
    chk("divovf_lo", lo, 32'h8000_0000);
    chk("divovf_hi", hi, 32'h0);
    step();

    ds0 = n_dstart;
    issue(3'd3, 32'd5, 32'd0, 3);
    wait_done(n);
    chk("div0_lo", lo, 32'hFFFF_FFFF);
    chk("div0_hi", hi, 32'd5);
    chk("div0_nostart", n_dstart - ds0, 0);
    step();

    issue(3'd5, 32'hABCD, 32'd0, 3);
    issue(3'd0, 32'd9, 32'd9, 3);
    repeat (4) step();
    reset = 1'b1;
    @(negedge clk);
    chk("rstw_ready", op_ready, 1);
    chk("rstw_hi", hi, 0);
    chk("rstw_lo", lo, 0);
    chk("rstw_mstart", mul_start, 0);
    step();
    reset = 1'b0;
    step();
    issue(3'd1, 32'd2, 32'd3, 3);
    wait_done(n);
    chk("fresh_lo", lo, 32'd6);
    chk("fresh_hi", hi, 32'd0);
    step();

    for (int k = 0; k < 300; k++) begin
      ra = pick();
      rb = ($urandom_range(0, 5) == 0) ? 32'h0 : pick();
      issue(3'($urandom_range(0, 7)), ra, rb,
            $urandom_range(1, 8));
      if ($urandom_range(0, 39) == 0) begin
        repeat ($urandom_range(0, 11)) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
      end else begin
        repeat ($urandom_range(0, 2)) step();
      end
    end
    wait_idle();
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
